// File: rtl/approx_mult_engine.sv
// Approximate/exact multiply engine: reads DEPTH operand pairs, normalises them with
// leading-one shifts, multiplies the K-bit heads and rescales, or multiplies exactly.
// state | meaning
// IDLE  | wait for start, latch mode
// READ  | issue input read at idx
// LOAD  | capture operands, flag zeros
// SHIFT | normalise A and B in parallel
// MULT  | compute and register product
// WRITE | write product at idx
// DONE  | one-cycle completion pulse
module approx_mult_engine #(
  parameter int W     = 16,
  parameter int K     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  output logic            busy,
  output logic            done,
  output logic            in_rd,
  output logic [AW-1:0]   in_addr,
  input  logic [2*W-1:0]  in_data,
  output logic            out_wr,
  output logic [AW-1:0]   out_addr,
  output logic [2*W-1:0]  out_data
);

  localparam int SW = $clog2(W) + 1;
  localparam int TW = SW + 2;
  localparam logic [TW-1:0] BASE = TW'(2*W - 2*K);

  typedef enum logic [2:0] {IDLE, READ, LOAD, SHIFT, MULT, WRITE, DONE} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic           mode_q, mode_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [SW-1:0]  sa_q, sa_d, sb_q, sb_d;
  logic           za_q, za_d, zb_q, zb_d;
  logic [2*W-1:0] out_data_q, out_data_d;

  logic [2*K-1:0] head_prod;
  logic [2*W-1:0] head_ext, approx_res, exact_res;
  logic [TW-1:0]  shift_sum;
  logic           a_fin, b_fin;

  assign head_prod = {{K{1'b0}}, a_q[W-1:W-K]} * {{K{1'b0}}, b_q[W-1:W-K]};
  assign head_ext  = (2*W)'(head_prod);
  assign shift_sum = TW'(sa_q) + TW'(sb_q);
  // Net scale is BASE - (sa+sb); split by sign so each shift amount stays unsigned.
  assign approx_res = (shift_sum <= BASE) ? (head_ext << (BASE - shift_sum))
                                          : (head_ext >> (shift_sum - BASE));
  assign exact_res = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
  assign a_fin = a_q[W-1] | za_q;
  assign b_fin = b_q[W-1] | zb_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      mode_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sa_q       <= '0;
      sb_q       <= '0;
      za_q       <= 1'b0;
      zb_q       <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      za_q       <= za_d;
      zb_q       <= zb_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    a_d        = a_q;
    b_d        = b_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    za_d       = za_q;
    zb_d       = zb_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: if (start) begin
        mode_d  = mode;
        idx_d   = '0;
        state_d = READ;
      end
      READ: state_d = LOAD;
      LOAD: begin
        a_d     = in_data[2*W-1:W];
        b_d     = in_data[W-1:0];
        sa_d    = '0;
        sb_d    = '0;
        za_d    = (in_data[2*W-1:W] == '0);
        zb_d    = (in_data[W-1:0] == '0);
        state_d = mode_q ? MULT : SHIFT;
      end
      SHIFT: begin
        if (a_fin && b_fin) begin
          state_d = MULT;
        end else begin
          if (!a_fin) begin
            a_d  = a_q << 1;
            sa_d = sa_q + 1'b1;
          end
          if (!b_fin) begin
            b_d  = b_q << 1;
            sb_d = sb_q + 1'b1;
          end
        end
      end
      MULT: begin
        if (mode_q)            out_data_d = exact_res;
        else if (za_q || zb_q) out_data_d = '0;
        else                   out_data_d = approx_res;
        state_d = WRITE;
      end
      WRITE: begin
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    in_rd    = (state_q == READ);
    out_wr   = (state_q == WRITE);
    in_addr  = idx_q;
    out_addr = idx_q;
    out_data = out_data_q;
  end

endmodule

// File: tb/tb_approx_mult_engine.sv
// Randomised scoreboard bench for approx_mult_engine against an arithmetic reference
// model of normalise / truncate / rescale, with directed corner pairs and a mid-run reset.
module tb_approx_mult_engine;
  localparam int W = 16;
  localparam int K = 8;
  localparam int DEPTH = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic busy, done, in_rd, out_wr;
  logic [AW-1:0] in_addr, out_addr;
  logic [2*W-1:0] in_data, out_data;
  logic [2*W-1:0] mem [DEPTH];

  typedef struct {
    logic [AW-1:0]  addr;
    logic [2*W-1:0] data;
    int             lat;
  } exp_t;
  exp_t sb_q[$];

  int n_pass = 0, n_total = 0;
  longint cyc = 0, rd_cyc = 0;
  int busy_cnt = 0, done_cnt = 0, wr_cnt = 0;

  approx_mult_engine #(.W(W), .K(K), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
    .in_rd(in_rd), .in_addr(in_addr), .in_data(in_data),
    .out_wr(out_wr), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (in_rd) in_data <= mem[in_addr];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int lead_zeros(input logic [W-1:0] x);
    if (x == '0) return 0;
    for (int i = W - 1; i >= 0; i--) if (x[i]) return W - 1 - i;
    return 0;
  endfunction

  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input bit m, output logic [2*W-1:0] r, output int lat);
    int sa, sb, s;
    longint unsigned ha, hb, p, res;
    sa = lead_zeros(a);
    sb = lead_zeros(b);
    if (m) begin
      res = longint'(a) * longint'(b);
      r = res[2*W-1:0];
      lat = 4;
      return;
    end
    lat = ((sa > sb) ? sa : sb) + 5;
    if (a == '0 || b == '0) begin
      r = '0;
      return;
    end
    ha = (longint'(a) << sa) >> (W - K);
    hb = (longint'(b) << sb) >> (W - K);
    p = ha * hb;
    s = 2*W - 2*K - sa - sb;
    res = (s >= 0) ? (p << s) : (p >> (-s));
    r = res[2*W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    v = W'($urandom);
    return v >> $urandom_range(0, W);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (in_rd) rd_cyc = cyc;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (out_wr) begin
      wr_cnt++;
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", out_addr, out_data);
      end else begin
        e = sb_q.pop_front();
        chk("out_addr", longint'(out_addr), longint'(e.addr));
        chk("out_data", longint'(out_data), longint'(e.data));
        chk("entry_latency", cyc - rd_cyc + 1, longint'(e.lat));
      end
    end
  end

  task automatic push_exp(input bit m, output int run_len);
    exp_t e;
    run_len = 1;
    for (int i = 0; i < DEPTH; i++) begin
      e.addr = AW'(i);
      ref_model(mem[i][2*W-1:W], mem[i][W-1:0], m, e.data, e.lat);
      run_len += e.lat;
      sb_q.push_back(e);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = {rnd_op(), rnd_op()};
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_rd"}, in_rd, 0);
    chk({tag, "_out_wr"}, out_wr, 0);
    chk({tag, "_in_addr"}, in_addr, 0);
    chk({tag, "_out_addr"}, out_addr, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  task automatic run(input bit m, input bit mid_start);
    int exp_len;
    bit seen = 0;
    push_exp(m, exp_len);
    busy_cnt = 0;
    done_cnt = 0;
    wr_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    mode = m;
    @(negedge clk);
    start = 1'b0;
    mode = ~m;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (mid_start && t == 10) start = 1'b1;
      if (mid_start && t == 11) start = 1'b0;
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("done_seen", seen, 1);
    @(negedge clk);
    chk("done_single_pulse", done, 0);
    @(negedge clk);
    chk("busy_after_run", busy, 0);
    chk("done_count", done_cnt, 1);
    chk("run_length", busy_cnt, exp_len);
    chk("write_count", wr_cnt, DEPTH);
    chk("queue_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic reset_mid_run();
    int exp_len;
    bit found = 0;
    fill_random();
    mem[3] = {16'h0001, 16'h0001};
    push_exp(1'b0, exp_len);
    @(negedge clk);
    start = 1'b1;
    mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (in_rd && in_addr == AW'(3)) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("reached_entry3", found, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check_outputs_zero("midrun_reset");
    rst = 1'b1;
    wr_cnt = 0;
    repeat (20) @(negedge clk);
    chk("no_write_after_reset", wr_cnt, 0);
    chk("idle_after_reset", busy, 0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;

    mem[0] = {16'h00F0, 16'h0300};
    mem[1] = {16'hFFFF, 16'hFFFF};
    mem[2] = {16'h0001, 16'h0001};
    mem[3] = {16'h0000, 16'h1234};
    mem[4] = {16'h0000, 16'h0000};
    mem[5] = {16'h8000, 16'h0001};
    mem[6] = {rnd_op(), rnd_op()};
    mem[7] = {16'h1234, 16'h0000};
    run(1'b0, 1'b0);
    run(1'b1, 1'b1);

    for (int r = 0; r < 4; r++) begin
      fill_random();
      run(r[0], r == 1);
    end

    reset_mid_run();
    fill_random();
    run(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
